// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: owns the PC, drives a 1-cycle synchronous ROM and
// registers the raw instruction plus its sliced ARM-style fields.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_en                 fetch enable (low = no new ROM requests)
//   o_rom_addr           ROM address (registered PC)
//   i_rom_data           ROM word for the address of the previous cycle
//   i_br_valid/target    redirect request and target PC
//   o_out_valid/i_out_ready  output handshake
//   o_out_pc/o_out_instr     PC and raw word of the presented instruction
//   o_out_cond..o_out_offset_br  decoded fields (pure bit slices)
//
// Build option: define FETCH_SKID_EN to add a 1-entry skid register that
// keeps a return arriving under backpressure; without it the return is
// dropped and its address is refetched.
module fetch_decode_stage #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data,
    input  logic              i_br_valid,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_pc,
    output logic [31:0]       o_out_instr,
    output logic [3:0]        o_out_cond,
    output logic [1:0]        o_out_op,
    output logic [3:0]        o_out_opcode,
    output logic              o_out_i,
    output logic              o_out_p,
    output logic              o_out_u,
    output logic              o_out_b,
    output logic              o_out_w,
    output logic              o_out_s,
    output logic [3:0]        o_out_rn,
    output logic [3:0]        o_out_rd,
    output logic [11:0]       o_out_operand2,
    output logic [23:0]       o_out_offset_br
);

    localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_pc;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_pc;
    logic [31:0]       r_out_instr;

    logic              w_accept;
    logic              w_issue;
    logic              w_load;
    logic              w_skid_full;
    logic [ADDR_W-1:0] w_load_pc;
    logic [31:0]       w_load_instr;

    assign w_accept = !r_out_valid || i_out_ready;

`ifdef FETCH_SKID_EN
    logic              r_skid_valid;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [31:0]       r_skid_instr;

    // A full skid never coexists with a return: it is only filled when
    // nothing was issued, and nothing is issued while it is full.
    assign w_skid_full  = r_skid_valid;
    assign w_load       = w_accept && (r_skid_valid || r_req_valid);
    assign w_load_pc    = r_skid_valid ? r_skid_pc : r_req_pc;
    assign w_load_instr = r_skid_valid ? r_skid_instr : i_rom_data;
`else
    assign w_skid_full  = 1'b0;
    assign w_load       = w_accept && r_req_valid;
    assign w_load_pc    = r_req_pc;
    assign w_load_instr = i_rom_data;
`endif

    assign w_issue = i_en && w_accept && !i_br_valid && !w_skid_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
`ifdef FETCH_SKID_EN
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
`endif
        end else if (i_br_valid) begin
            // Redirect discards everything in flight or on display.
            r_pc        <= i_br_target;
            r_req_valid <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef FETCH_SKID_EN
            r_skid_valid <= 1'b0;
`endif
        end else begin
            r_req_valid <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + LP_STEP;
            end
`ifndef FETCH_SKID_EN
            // Return lost to backpressure: rewind so it is refetched.
            else if (r_req_valid && !w_accept) begin
                r_pc <= r_req_pc;
            end
`endif

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= w_load_pc;
                r_out_instr <= w_load_instr;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end

`ifdef FETCH_SKID_EN
            if (r_skid_valid && w_accept) begin
                r_skid_valid <= 1'b0;
            end else if (r_req_valid && !w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= i_rom_data;
            end
`endif
        end
    end

    assign o_rom_addr      = r_pc;
    assign o_out_valid     = r_out_valid;
    assign o_out_pc        = r_out_pc;
    assign o_out_instr     = r_out_instr;
    // P/U/B/W/S deliberately alias opcode bits; consumer picks by op.
    assign o_out_cond      = r_out_instr[31:28];
    assign o_out_op        = r_out_instr[27:26];
    assign o_out_opcode    = r_out_instr[24:21];
    assign o_out_i         = r_out_instr[25];
    assign o_out_p         = r_out_instr[24];
    assign o_out_u         = r_out_instr[23];
    assign o_out_b         = r_out_instr[22];
    assign o_out_w         = r_out_instr[21];
    assign o_out_s         = r_out_instr[20];
    assign o_out_rn        = r_out_instr[19:16];
    assign o_out_rd        = r_out_instr[15:12];
    assign o_out_operand2  = r_out_instr[11:0];
    assign o_out_offset_br = r_out_instr[23:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus random traffic,
// checked by a program-order scoreboard and a separate monitor.
module tb_fetch_decode_stage;

    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [31:0]   out_instr;
    logic [3:0]    out_cond;
    logic [1:0]    out_op;
    logic [3:0]    out_opcode;
    logic          out_i, out_p, out_u, out_b, out_w, out_s;
    logic [3:0]    out_rn;
    logic [3:0]    out_rd;
    logic [11:0]   out_operand2;
    logic [23:0]   out_offset_br;

    int n_chk = 0;
    int n_fail = 0;
    int n_hs = 0;
    int idle = 0;

    logic [31:0]   rom [256];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] fill_pc;

    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_pc;
    logic [31:0]   prev_instr;

    logic [AW-1:0] col_pc [4];
    int            col_idx [4];
    int            col_n;

    fetch_decode_stage #(
        .ADDR_W  (AW),
        .RESET_PC(8'h00),
        .PC_STEP (1)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .i_br_valid     (br_valid),
        .i_br_target    (br_target),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_pc       (out_pc),
        .o_out_instr    (out_instr),
        .o_out_cond     (out_cond),
        .o_out_op       (out_op),
        .o_out_opcode   (out_opcode),
        .o_out_i        (out_i),
        .o_out_p        (out_p),
        .o_out_u        (out_u),
        .o_out_b        (out_b),
        .o_out_w        (out_w),
        .o_out_s        (out_s),
        .o_out_rn       (out_rn),
        .o_out_rd       (out_rd),
        .o_out_operand2 (out_operand2),
        .o_out_offset_br(out_offset_br)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream is simply consecutive PCs from the last start point.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(fill_pc);
            fill_pc = fill_pc + 8'd1;
        end
    endtask

    task automatic restart(input logic [AW-1:0] start);
        exp_q.delete();
        fill_pc = start;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic redirect(input logic [AW-1:0] t);
        br_valid  = 1'b1;
        br_target = t;
        restart(t);
        step();
        br_valid = 1'b0;
    endtask

    task automatic wait_pc(input logic [AW-1:0] pc);
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_pc == pc) break;
            step();
        end
        chk("wait_pc", {63'd0, out_valid && out_pc == pc}, 64'd1);
    endtask

    task automatic collect(input int n);
        col_n = 0;
        for (int c = 0; c < 20 && col_n < n; c++) begin
            if (out_valid) begin
                col_pc[col_n]  = out_pc;
                col_idx[col_n] = c;
                col_n++;
            end
            if (col_n < n) step();
        end
        chk("collect_cnt", col_n, n);
    endtask

    // Monitor: pops the scoreboard on every accepted output.
    always @(negedge clk) begin
        logic [31:0] e;
        if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_pc", out_pc, prev_pc);
            chk("hold_instr", out_instr, prev_instr);
        end
        prev_stall = !rst && !br_valid && out_valid && !out_ready;
        prev_pc    = out_pc;
        prev_instr = out_instr;

        if (rst || br_valid) begin
            idle = 0;
        end else if (out_valid && out_ready) begin
            idle = 0;
            n_hs++;
            chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                chk("sb_pc", out_pc, exp_q[0]);
                e = rom[exp_q[0]];
                chk("sb_instr", out_instr, e);
                chk("sb_fields",
                    {out_cond, out_op, out_i, out_p, out_u, out_b, out_w,
                     out_s, out_rn, out_rd, out_operand2}, e);
                chk("sb_opcode", out_opcode, e[24:21]);
                chk("sb_offset", out_offset_br, e[23:0]);
                void'(exp_q.pop_front());
            end
        end else begin
            idle++;
        end
        chk("watchdog", {63'd0, idle > 60}, 64'd0);
        if (idle > 60) idle = 0;
    end

    initial begin
        for (int k = 0; k < 256; k++) rom[k] = 32'hE080_0000 | k;
        for (int k = 8'h80; k < 8'hC0; k++) rom[k] = $urandom;
        rom[8'h30] = 32'hE591_2004;
        rom[8'h31] = 32'hEAFF_FFFE;

        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        restart(8'h00);
        step();
        step();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_cond", out_cond, 0);
        chk("rst_offset", out_offset_br, 0);

        // Reset release and steady stream.
        rst = 1'b0;
        restart(8'h00);
        step();
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_pc", out_pc, 0);
        chk("str_cond", out_cond, 4'hE);
        chk("str_op", out_op, 0);
        chk("str_opcode", out_opcode, 4'h4);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("str_valid", {63'd0, out_valid}, 64'd1);
            chk("str_pc", out_pc, k);
        end

        // Redirect while pc 5 is presented.
        wait_pc(8'h05);
        redirect(8'h40);
        chk("br_bub1", {63'd0, out_valid}, 64'd0);
        step();
        chk("br_bub2", {63'd0, out_valid}, 64'd0);
        step();
        chk("br_valid", {63'd0, out_valid}, 64'd1);
        chk("br_pc0", out_pc, 8'h40);
        step();
        chk("br_pc1", out_pc, 8'h41);

        // Backpressure for three cycles at pc 10.
        redirect(8'h08);
        wait_pc(8'h0A);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold", {out_valid, out_pc}, {1'b1, 8'h0A});
        end
        out_ready = 1'b1;
        collect(3);
        chk("bp_seq0", col_pc[0], 8'h0A);
        chk("bp_seq1", col_pc[1], 8'h0B);
        chk("bp_seq2", col_pc[2], 8'h0C);

        // Address wrap with no gap.
        redirect(8'hFE);
        collect(4);
        chk("wrap0", col_pc[0], 8'hFE);
        chk("wrap1", col_pc[1], 8'hFF);
        chk("wrap2", col_pc[2], 8'h00);
        chk("wrap3", col_pc[3], 8'h01);
        chk("wrap_gap", col_idx[3] - col_idx[0], 3);

        // Field decode of a load and a branch word.
        redirect(8'h30);
        wait_pc(8'h30);
        chk("dec_cond", out_cond, 4'hE);
        chk("dec_op", out_op, 2'd1);
        chk("dec_ipubws",
            {out_i, out_p, out_u, out_b, out_w, out_s}, 6'b011001);
        chk("dec_rn", out_rn, 4'd1);
        chk("dec_rd", out_rd, 4'd2);
        chk("dec_op2", out_operand2, 12'h004);
        step();
        chk("dec_br_pc", out_pc, 8'h31);
        chk("dec_br_op", out_op, 2'd2);
        chk("dec_br_off", out_offset_br, 24'hFFFFFE);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            en        = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 3) begin
                br_valid  = 1'b1;
                br_target = AW'($urandom_range(0, 255));
                restart(br_target);
            end else begin
                br_valid = 1'b0;
            end
            step();
        end

        // Reset in mid-stream with a request in flight.
        en        = 1'b1;
        out_ready = 1'b1;
        br_valid  = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        restart(8'h00);
        step();
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_addr", rom_addr, 0);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_instr", out_instr, 0);
        chk("mrst_fields",
            {out_opcode, out_rn, out_operand2, out_s}, 0);
        rst = 1'b0;
        step();
        chk("mrst_lat_early", {63'd0, out_valid}, 64'd0);
        step();
        chk("mrst_lat", {out_valid, out_pc}, {1'b1, 8'h00});

        step();
        step();
        chk("handshakes", {63'd0, n_hs > 100}, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Parametrised instruction fetch/decode stage: owns the program counter, drives a synchronous instruction ROM (one-cycle read latency) and registers the decoded 32-bit ARM-style instruction fields behind a valid/ready handshake. It merges the separate free-running counter, ROM and combinational decoder into one pipelined stage. It adds branch redirect, flush, backpressure and configurable PC width, reset vector and step. It sits between the instruction ROM and the execute stage.

## Interface
- ADDR_W, 8, PC and ROM address width
- RESET_PC, 0, PC value after reset (ADDR_W bits)
- PC_STEP, 1, PC increment per fetched instruction (1 = word-addressed ROM)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  fetch enable; low = no new ROM requests issued
- rom_addr  out  ADDR_W  ROM read address (= PC register)
- rom_data  in  32  ROM data for the address presented in the previous cycle
- br_valid  in  1  redirect request
- br_target  in  ADDR_W  redirect target PC
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_pc  out  ADDR_W  PC of the presented instruction
- out_instr  out  32  raw instruction word
- out_cond, out_op, out_opcode  out  4/2/4  [31:28], [27:26], [24:21]
- out_i, out_p, out_u, out_b, out_w, out_s  out  1 each  [25], [24], [23], [22], [21], [20]
- out_rn, out_rd  out  4 each  [19:16], [15:12]
- out_operand2  out  12  [11:0]
- out_offset_br  out  24  [23:0]

## Operation
- Reset: pc=RESET_PC, req_valid=0, out_valid=0, every out_* field and out_pc = 0. The same applies when rst rises mid-operation; rst has priority over all inputs.
- accept = !out_valid || out_ready.
- Issue: a request is issued in a cycle when en && accept && !br_valid. The issued address is rom_addr=pc. Next edge: req_valid<=1, req_pc<=pc, pc<=pc+PC_STEP (mod 2^ADDR_W; wraps from 2^ADDR_W-1 to 0). Otherwise req_valid<=0 and pc holds.
- Return: when req_valid is set, rom_data belongs to req_pc.
  - If accept: the output register loads rom_data, its decoded fields and req_pc; out_valid<=1.
  - Otherwise: see Configuration.
- Handshake: when out_valid && out_ready and nothing returns, out_valid<=0. While out_valid && !out_ready, all out_* hold stable.
- Redirect (br_valid=1):
  - Next edge: pc<=br_target, req_valid<=0, out_valid<=0, skid emptied.
  - In-flight and presented instructions are discarded, even if out_ready=1 in the same cycle.
  - No issue occurs in the br_valid cycle. The first fetch of br_target is issued the following cycle.
- en=0: no new issues; an in-flight return still completes normally.
- Decode is pure field slicing. P/U/B/W/S overlap OpCode bits by design; the consumer selects by out_op.

## Timing
- Fetch-to-output latency: 2 cycles (issue edge, then output-register edge). Example: pc issued at edge N appears on out_* after edge N+1.
- Throughput: 1 instruction/cycle with out_ready held high.
- Redirect penalty: 2 bubble cycles. out_valid is low for 2 cycles after the br_valid edge; the target instruction is valid after the 3rd edge.
- rom_addr changes only on clock edges (registered PC). There is no combinational path from rom_data to rom_addr.

## Configuration
- FETCH_SKID_EN defined:
  - A 1-entry skid register {valid, pc, instr} captures a return that arrives while !accept.
  - No new issue occurs while the skid is full.
  - When accept rises, the skid drains into the output register before any new return.
  - No instruction is ever refetched.
- FETCH_SKID_EN undefined:
  - A return that arrives while !accept is dropped.
  - Next edge: pc<=req_pc (replay), so the same address is refetched once accept allows.
  - Program order is preserved; up to 2 cycles are lost per stall.
- Redirect flushes the skid in both builds.

## Test plan
- Reset and stream: rst 2 cycles, RESET_PC=0, ROM[k]=0xE0800000|k, out_ready=1, en=1. Required: out_valid first high 2 cycles after rst falls, out_pc=0,1,2… consecutively, out_cond=0xE, out_op=0, out_opcode=4.
- Wrap: ADDR_W=4, pc runs 14,15,0,1. Required: out_pc sequence 14,15,0,1 with no gap.
- Redirect: br_valid=1, br_target=0x40 while out_pc=5 is presented. Required: the pc 5 and in-flight 6 instructions are discarded, 2 invalid cycles, then out_pc=0x40, 0x41.
- Backpressure: out_ready low for 3 cycles at out_pc=10. Required: out_* hold at pc 10; after release, 11, 12 follow with none skipped or duplicated, in both FETCH_SKID_EN builds.
- Field decode: ROM word 0xE5912004. Required: cond=0xE, op=1, i=0, p=1, u=1, b=0, w=0, s=1 (L), rn=1, rd=2, operand2=0x004; branch word 0xEAFFFFFE gives op=2, offset_br=0xFFFFFE.
- Mid-run reset: rst pulse while out_valid=1 and a request is in flight. Required: next cycle out_valid=0, rom_addr=RESET_PC, and all out_* are 0.
